// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, command/response codes, timing helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    WAIT_IDLE,
    DONE
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
  localparam logic [7:0] PS2_RSP_BAT_OK   = 8'hAA;

  function automatic logic [23:0] us_to_cyc(input int unsigned clk_hz, input int unsigned us);
    return 24'(clk_hz / 1_000_000 * us);
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pads, with clock falling-edge detect.
module ps2_line_sync
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clk_pad,
  input  logic data_pad,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fe
);

  logic [2:0] clk_ff;
  logic [1:0] data_ff;

  // Reset to the idle-high bus level so release never looks like an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_ff  <= 3'b111;
      data_ff <= 2'b11;
    end else begin
      clk_ff  <= {clk_ff[1:0], clk_pad};
      data_ff <= {data_ff[0], data_pad};
    end
  end

  assign clk_sync  = clk_ff[1];
  assign data_sync = data_ff[1];
  assign clk_fe    = clk_ff[2] & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift on device clock, ack check.
// Optional per-edge watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned INHIBIT_US = 100,
  parameter int unsigned RTS_US     = 1,
  parameter int unsigned TIMEOUT_US = 15000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_ack_ok,
  output logic       tx_err
);

  localparam logic [23:0] INHIBIT_LAST = us_to_cyc(CLK_HZ, INHIBIT_US) - 24'd1;
  localparam logic [23:0] RTS_LAST     = us_to_cyc(CLK_HZ, RTS_US) - 24'd1;
  localparam logic [23:0] TIMEOUT_LAST = us_to_cyc(CLK_HZ, TIMEOUT_US) - 24'd1;

  ps2_state_e  state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic        parity_q, parity_d;
  logic        data_q, data_d;
  logic        ack_q, ack_d;
  logic        rdy_q;
  logic        clk_sync, data_sync, clk_fe;

  ps2_line_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .clk_pad   (ps2_clk_in),
    .data_pad  (ps2_data_in),
    .clk_sync  (clk_sync),
    .data_sync (data_sync),
    .clk_fe    (clk_fe)
  );

`ifdef PS2_TX_TIMEOUT_EN
  logic err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_LAST;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    parity_d = parity_q;
    data_d   = data_q;
    ack_d    = ack_q;
`ifdef PS2_TX_TIMEOUT_EN
    err_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          shreg_d  = tx_data;
          parity_d = ~^tx_data;
          bitcnt_d = 4'd0;
          cnt_d    = 24'd0;
          data_d   = 1'b0;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q == INHIBIT_LAST) begin
          cnt_d   = 24'd0;
          state_d = RTS;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      RTS: begin
        if (cnt_q == RTS_LAST) begin
          cnt_d   = 24'd0;
          data_d  = 1'b1;  // start bit stays on the line until the first device edge
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      SHIFT: begin
        if (clk_fe) begin
          bitcnt_d = bitcnt_q + 4'd1;
          cnt_d    = 24'd0;
          if (bitcnt_q < 4'd8) begin
            data_d = ~shreg_q[bitcnt_q[2:0]];
          end else if (bitcnt_q == 4'd8) begin
            data_d = ~parity_q;
          end else if (bitcnt_q == 4'd9) begin
            data_d = 1'b0;
          end else begin
            ack_d   = ~data_sync;
            state_d = WAIT_IDLE;
          end
        end
`ifdef PS2_TX_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
`endif
      end
      WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          state_d = DONE;
        end
`ifdef PS2_TX_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 24'd0;
      shreg_q  <= 8'd0;
      bitcnt_q <= 4'd0;
      parity_q <= 1'b0;
      data_q   <= 1'b0;
      ack_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      parity_q <= parity_d;
      data_q   <= data_d;
      ack_q    <= ack_d;
      rdy_q    <= 1'b1;
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign tx_err = err_q;
`else
  assign tx_err = 1'b0;
`endif

  // Line drives decode straight from state so reset releases the pads asynchronously.
  assign ps2_clk_oe  = (state_q == INHIBIT) || (state_q == RTS);
  assign ps2_data_oe = (state_q == RTS) || ((state_q == SHIFT) && data_q);
  assign tx_ready    = rdy_q && (state_q == IDLE);
  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign tx_done     = (state_q == DONE);
  assign tx_ack_ok   = (state_q == DONE) && ack_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device (1 MHz clock, 40-cycle half period).
module tb_ps2_host_tx;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int HALF = 40;
  localparam int INH  = 100;
  localparam int TMO  = 15000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       busy, tx_done, tx_ack_ok, tx_err;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int inh_cnt = 0;
  logic last_ack = 1'b0;
  logic prev_clk_oe = 1'b0;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_HZ     (CLK_HZ),
    .INHIBIT_US (100),
    .RTS_US     (1),
    .TIMEOUT_US (15000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_ack_ok   (tx_ack_ok),
    .tx_err      (tx_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done) begin
      last_ack <= tx_ack_ok;
      done_cnt <= done_cnt + 1;
    end
    if (tx_err) err_cnt <= err_cnt + 1;
    if (ps2_clk_oe && !prev_clk_oe) inh_cnt <= inh_cnt + 1;
    prev_clk_oe <= ps2_clk_oe;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame as seen by the device: data LSB first, odd parity, stop=1.
  function automatic logic [9:0] expect_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
  endfunction

  task automatic start_frame(input logic [7:0] b, output int inh, output int rts);
    int n = 0;
    inh = 0;
    rts = 0;
    while (!tx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_send", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    for (int i = 0; i < 1000; i++) begin
      if (!ps2_clk_oe) break;
      if (ps2_data_oe) rts++;
      else inh++;
      @(negedge clk);
    end
  endtask

  task automatic device_clocks(input int nclk, input bit ack, output logic [9:0] cap);
    cap = '0;
    repeat (HALF) @(negedge clk);
    for (int k = 1; k <= nclk; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k <= 10) cap[k-1] = ps2_data_in;
      if (k == 10 && ack) begin
        repeat (HALF / 2) @(negedge clk);
        dev_data_low = 1'b1;
        repeat (HALF / 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    repeat (5) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic full_frame(input logic [7:0] b, input bit ack, input bit poke, input string tag);
    int inh, rts, d0, f0;
    logic [9:0] cap;
    d0 = done_cnt;
    f0 = inh_cnt;
    start_frame(b, inh, rts);
    check({tag, "_inhibit_cycles"}, inh, INH);
    check({tag, "_rts_cycles"}, rts, 1);
    if (poke) begin
      check({tag, "_ready_mid_frame"}, tx_ready, 0);
      tx_data  = ~b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
    end
    device_clocks(11, ack, cap);
    check({tag, "_frame_bits"}, cap, expect_frame(b));
    for (int i = 0; i < 200 && done_cnt == d0; i++) @(negedge clk);
    check({tag, "_done_seen"}, done_cnt != d0, 1);
    check({tag, "_ack_ok"}, last_ack, ack);
    repeat (200) @(negedge clk);
    check({tag, "_done_count"}, done_cnt, d0 + 1);
    check({tag, "_frames_on_bus"}, inh_cnt, f0 + 1);
    check({tag, "_idle_after"}, {busy, ps2_clk_oe, ps2_data_oe}, 3'b000);
  endtask

  initial begin
    int inh, rts, d0, e0, n;
    logic [9:0] cap, ref_frame;
    logic [7:0] rb;
    bit ra;

    // Reset and idle behaviour.
    repeat (3) @(negedge clk);
    check("rst_lines", {ps2_clk_oe, ps2_data_oe, busy}, 3'b000);
    check("rst_pulses", {tx_done, tx_ack_ok, tx_err}, 3'b000);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", tx_ready, 1);
    repeat (1000) @(negedge clk);
    check("idle_no_pulses", done_cnt + err_cnt, 0);
    check("idle_lines", {ps2_clk_oe, ps2_data_oe, busy}, 3'b000);

    // Enable reporting, reset (parity 1) with an ignored mid-frame request, NACK on 0x00.
    full_frame(8'hF4, 1'b1, 1'b0, "f4");
    ref_frame = 10'b1_0_1111_0100;
    check("f4_literal_model", expect_frame(8'hF4), ref_frame);
    full_frame(8'hFF, 1'b1, 1'b1, "ff");
    full_frame(8'h00, 1'b0, 1'b0, "nack00");

    // Randomized bytes and ack responses.
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom_range(0, 255));
      ra = 1'($urandom_range(0, 1));
      full_frame(rb, ra, 1'b0, "rand");
    end

    // Reset during SHIFT after four data bits.
    d0 = done_cnt;
    start_frame(8'h00, inh, rts);
    device_clocks(4, 1'b0, cap);
    ref_frame = expect_frame(8'h00);
    check("rst_mid_bits", cap[3:0], ref_frame[3:0]);
    check("rst_mid_pre_state", {busy, ps2_data_oe}, 2'b11);
    #2 reset = 1'b1;
    #1 check("rst_mid_release", {ps2_clk_oe, ps2_data_oe, busy}, 3'b000);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    check("rst_mid_no_done", done_cnt, d0);
    full_frame(8'hF3, 1'b1, 1'b0, "f3");

    // Device never clocks after request-to-send.
    d0 = done_cnt;
    e0 = err_cnt;
    start_frame(8'hF4, inh, rts);
`ifdef PS2_TX_TIMEOUT_EN
    n = 0;
    while (err_cnt == e0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("timeout_window", (n >= TMO - 5) && (n <= TMO + 5), 1);
    repeat (3) @(negedge clk);
    check("timeout_err_count", err_cnt, e0 + 1);
    check("timeout_release", {ps2_clk_oe, ps2_data_oe, busy}, 3'b000);
    check("timeout_no_done", done_cnt, d0);
`else
    n = 0;
    repeat (20000) @(negedge clk);
    check("no_timeout_busy", busy, 1);
    check("no_timeout_err", err_cnt, e0 + n);
    check("no_timeout_lines", {ps2_clk_oe, ps2_data_oe}, 2'b01);
    check("no_timeout_no_done", done_cnt, d0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("no_timeout_recovered", {busy, tx_ready}, 2'b01);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
